// File: rtl/nfc_acg_pkg.sv
// Shared ACG definitions: CA-sequencer state encoding, slot index, byte limits
// and default NAND interface timing.
package nfc_acg_pkg;

  localparam int unsigned AcgSlotCa        = 3;
  localparam int unsigned MaxAddrBytes     = 5;
  localparam int unsigned CaDataWidth      = 40;
  localparam int unsigned ByteCountWidth   = 3;
  localparam int unsigned TimerWidth       = 8;
  localparam int unsigned DefSetupCycles   = 1;
  localparam int unsigned DefWePulseCycles = 2;
  localparam int unsigned DefWeHoldCycles  = 2;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_SETUP  = 4'b0010,
    ST_WELOW  = 4'b0100,
    ST_WEHIGH = 4'b1000
  } ca_state_e;

  // One command byte, or 1..MaxAddrBytes address bytes (count-minus-one clamped).
  function automatic logic [ByteCountWidth-1:0] ca_byte_count(input logic       is_cmd,
                                                              input logic [15:0] num_minus_one);
    if (is_cmd) begin
      return ByteCountWidth'(1);
    end else if (num_minus_one >= 16'(MaxAddrBytes - 1)) begin
      return ByteCountWidth'(MaxAddrBytes);
    end else begin
      return ByteCountWidth'(num_minus_one) + ByteCountWidth'(1);
    end
  endfunction

endpackage

// File: rtl/nfc_phase_timer.sv
// Loadable down-counter that times each phase of the CA latch sequence;
// flags the terminal count now and on the following cycle.
module nfc_phase_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             iSystemClock,
  input  logic             iReset,
  input  logic             iLoad,
  input  logic [Width-1:0] iLoadValue,
  output logic             oExpire_c,
  output logic             oExpireNext_c
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (iLoad) begin
      count_d = iLoadValue;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign oExpire_c     = (count_q == '0);
  assign oExpireNext_c = iLoad ? (iLoadValue == '0) : (count_q == Width'(1));

endmodule

// File: rtl/nfc_atom_ca_latch.sv
// ACG CA-sequencer responder: serialises a command byte or 1-5 address bytes
// onto the NAND pins with WE# strobes. NFC_CE_HOLD_EN keeps CE# asserted in idle.
module nfc_atom_ca_latch
  import nfc_acg_pkg::*;
#(
  parameter int unsigned NumberOfWays  = 4,
  parameter int unsigned SetupCycles   = DefSetupCycles,
  parameter int unsigned WEPulseCycles = DefWePulseCycles,
  parameter int unsigned WEHoldCycles  = DefWeHoldCycles
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic                    iStart,
  output logic                    oReady,
  output logic                    oLastStep,
  input  logic [NumberOfWays-1:0] iTargetWay,
  input  logic                    iCASelect,
  input  logic [39:0]             iCAData,
  input  logic [15:0]             iNumOfData,
  output logic [NumberOfWays-1:0] oPO_ChipEnable,
  output logic                    oPO_CLE,
  output logic                    oPO_ALE,
  output logic                    oPO_WE,
  output logic [7:0]              oPO_DQ,
  output logic                    oPO_DQOE
);

  ca_state_e                   state_q, state_d;
  logic [NumberOfWays-1:0]     way_q, way_d;
  logic                        sel_q, sel_d;
  logic [CaDataWidth-1:0]      shift_q, shift_d;
  logic [ByteCountWidth-1:0]   bytes_q, bytes_d;

  logic                        ready_q, ready_d;
  logic                        last_step_q, last_step_d;
  logic [NumberOfWays-1:0]     ce_q, ce_d;
  logic                        cle_q, cle_d;
  logic                        ale_q, ale_d;
  logic                        we_q, we_d;
  logic [7:0]                  dq_q, dq_d;
  logic                        dqoe_q, dqoe_d;

  logic                        timer_load;
  logic [TimerWidth-1:0]       timer_value;
  logic                        expire_c;
  logic                        expire_next_c;
  logic                        busy;
  logic [NumberOfWays-1:0]     idle_ce;

  nfc_phase_timer #(
    .Width (TimerWidth)
  ) u_phase_timer (
    .iSystemClock (iSystemClock),
    .iReset       (iReset),
    .iLoad        (timer_load),
    .iLoadValue   (timer_value),
    .oExpire_c    (expire_c),
    .oExpireNext_c(expire_next_c)
  );

  // Next-state, phase timer reload and registered pin values.
  always_comb begin
    state_d     = state_q;
    way_d       = way_q;
    sel_d       = sel_q;
    shift_d     = shift_q;
    bytes_d     = bytes_q;
    timer_value = '0;

    case (state_q)
      ST_IDLE: begin
        if (iStart && ready_q) begin
          state_d = ST_SETUP;
          way_d   = iTargetWay;
          sel_d   = iCASelect;
          shift_d = iCAData;
          bytes_d = ca_byte_count(iCASelect, iNumOfData);
        end
      end
      ST_SETUP:  if (expire_c) state_d = ST_WELOW;
      ST_WELOW:  if (expire_c) state_d = ST_WEHIGH;
      ST_WEHIGH: begin
        if (expire_c) begin
          if (bytes_q > ByteCountWidth'(1)) begin
            state_d = ST_SETUP;
            bytes_d = bytes_q - ByteCountWidth'(1);
            shift_d = {shift_q[CaDataWidth-9:0], 8'h00};
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    timer_load = (state_d != state_q);
    case (state_d)
      ST_SETUP:  timer_value = TimerWidth'(SetupCycles - 1);
      ST_WELOW:  timer_value = TimerWidth'(WEPulseCycles - 1);
      ST_WEHIGH: timer_value = TimerWidth'(WEHoldCycles - 1);
      default:   timer_value = '0;
    endcase

`ifdef NFC_CE_HOLD_EN
    idle_ce = way_q;
`else
    idle_ce = '1;
`endif

    busy        = (state_d != ST_IDLE);
    ready_d     = ~busy;
    last_step_d = (state_d == ST_WEHIGH) && expire_next_c && (bytes_d == ByteCountWidth'(1));
    ce_d        = busy ? way_d : idle_ce;
    cle_d       = busy & sel_d;
    ale_d       = busy & ~sel_d;
    dqoe_d      = busy;
    we_d        = (state_d != ST_WELOW);
    // DQ only moves when a byte enters SETUP, so it is frozen around WE#.
    dq_d        = (state_d == ST_SETUP) ? shift_d[CaDataWidth-1 -: 8] : dq_q;
  end

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      state_q     <= ST_IDLE;
      way_q       <= '1;
      sel_q       <= 1'b0;
      shift_q     <= '0;
      bytes_q     <= '0;
      ready_q     <= 1'b1;
      last_step_q <= 1'b0;
      ce_q        <= '1;
      cle_q       <= 1'b0;
      ale_q       <= 1'b0;
      we_q        <= 1'b1;
      dq_q        <= 8'h00;
      dqoe_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      way_q       <= way_d;
      sel_q       <= sel_d;
      shift_q     <= shift_d;
      bytes_q     <= bytes_d;
      ready_q     <= ready_d;
      last_step_q <= last_step_d;
      ce_q        <= ce_d;
      cle_q       <= cle_d;
      ale_q       <= ale_d;
      we_q        <= we_d;
      dq_q        <= dq_d;
      dqoe_q      <= dqoe_d;
    end
  end

  assign oReady         = ready_q;
  assign oLastStep      = last_step_q;
  assign oPO_ChipEnable = ce_q;
  assign oPO_CLE        = cle_q;
  assign oPO_ALE        = ale_q;
  assign oPO_WE         = we_q;
  assign oPO_DQ         = dq_q;
  assign oPO_DQOE       = dqoe_q;

endmodule

// File: tb/tb_nfc_atom_ca_latch.sv
// Scoreboard bench for nfc_atom_ca_latch: expected latched bytes and sequence
// lengths are queued by the driver and consumed by a pin monitor.
module tb_nfc_atom_ca_latch;

  localparam int unsigned W  = 4;
  localparam int unsigned S  = 1;
  localparam int unsigned P  = 2;
  localparam int unsigned H  = 2;

  typedef struct packed {
    logic       cle;
    logic       ale;
    logic [3:0] ce;
    logic [7:0] dq;
  } byte_exp_t;

  typedef struct packed {
    logic [15:0] cycles;
    logic [3:0]  way;
  } done_exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] way;
  logic         sel;
  logic [39:0]  data;
  logic [15:0]  num;
  logic         oReady, oLastStep, oPO_CLE, oPO_ALE, oPO_WE, oPO_DQOE;
  logic [W-1:0] oPO_ChipEnable;
  logic [7:0]   oPO_DQ;

  byte_exp_t    byte_q[$];
  done_exp_t    done_q[$];
  logic [W-1:0] idle_way;
  int           n_checks;
  int           n_fail;
  int           we_edges;

  nfc_atom_ca_latch #(
    .NumberOfWays (W),
    .SetupCycles  (S),
    .WEPulseCycles(P),
    .WEHoldCycles (H)
  ) dut (
    .iSystemClock  (clk),
    .iReset        (rst),
    .iStart        (start),
    .oReady        (oReady),
    .oLastStep     (oLastStep),
    .iTargetWay    (way),
    .iCASelect     (sel),
    .iCAData       (data),
    .iNumOfData    (num),
    .oPO_ChipEnable(oPO_ChipEnable),
    .oPO_CLE       (oPO_CLE),
    .oPO_ALE       (oPO_ALE),
    .oPO_WE        (oPO_WE),
    .oPO_DQ        (oPO_DQ),
    .oPO_DQOE      (oPO_DQOE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte list and duration straight from the request fields.
  task automatic push_req(input logic [W-1:0] w, input logic s, input logic [39:0] d,
                          input logic [15:0] n);
    int        nb;
    byte_exp_t be;
    done_exp_t de;
    if (s) nb = 1;
    else   nb = (n > 16'd4) ? 5 : int'(n) + 1;
    for (int i = 0; i < nb; i++) begin
      be.cle = s;
      be.ale = ~s;
      be.ce  = w;
      be.dq  = d[39 - 8*i -: 8];
      byte_q.push_back(be);
    end
    de.cycles = 16'(nb * (S + P + H));
    de.way    = w;
    done_q.push_back(de);
  endtask

  // Called at a negedge; returns at the negedge where oLastStep is seen.
  task automatic run_req(input logic [W-1:0] w, input logic s, input logic [39:0] d,
                         input logic [15:0] n, input bit chained, input bit hold);
    bit got;
    way   = w;
    sel   = s;
    data  = d;
    num   = n;
    start = 1'b1;
    push_req(w, s, d, n);
    if (chained) @(negedge clk);
    @(negedge clk);
    check("accepted", 64'(oReady), 64'(0));
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (oLastStep) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("last_step_timeout", 64'(got), 64'(1));
    if (!hold) start = 1'b0;
  endtask

  // Pin monitor: pops an expected byte at every WE# rising edge and an
  // expected sequence length at every oLastStep.
  initial begin
    logic        pw, pcle, pale;
    logic [W-1:0] pce;
    logic [7:0]  pdq;
    int          low_run, busy;
    bit          exp_ready;
    logic [W-1:0] exp_ce;
    byte_exp_t   be;
    done_exp_t   de;
    pw = 1'b1; pcle = 1'b0; pale = 1'b0; pce = '1; pdq = '0;
    low_run = 0; busy = 0; exp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pw = 1'b1; low_run = 0; busy = 0; exp_ready = 1'b0; idle_way = '1;
      end else begin
        if (!oPO_WE) low_run++;
        if (pw === 1'b0 && oPO_WE === 1'b1) begin
          we_edges++;
          if (byte_q.size() == 0) begin
            check("we_edge_pending", 64'(byte_q.size()), 64'(1));
          end else begin
            be = byte_q.pop_front();
            check("we_edge_byte", 64'({pcle, pale, pce, pdq}), 64'(be));
          end
          check("we_low_width", 64'(low_run), 64'(P));
          low_run = 0;
        end
        if (pw === 1'b0 && oPO_WE === 1'b0) check("dq_stable_we_low", 64'(oPO_DQ), 64'(pdq));
        if (oPO_CLE && oPO_ALE) check("cle_ale_exclusive", 64'({oPO_CLE, oPO_ALE}), 64'(0));
        if (!oReady) busy++;
        if (exp_ready) begin
          check("ready_after_last", 64'(oReady), 64'(1));
          exp_ready = 1'b0;
        end
        if (oLastStep) begin
          if (done_q.size() == 0) begin
            check("last_step_pending", 64'(done_q.size()), 64'(1));
          end else begin
            de = done_q.pop_front();
            check("seq_cycles", 64'(busy), 64'(de.cycles));
            idle_way = de.way;
          end
          busy = 0;
          exp_ready = 1'b1;
        end else if (oReady) begin
`ifdef NFC_CE_HOLD_EN
          exp_ce = idle_way;
`else
          exp_ce = '1;
`endif
          check("idle_pins", 64'({oPO_ChipEnable, oPO_CLE, oPO_ALE, oPO_WE, oPO_DQOE}),
                64'({exp_ce, 1'b0, 1'b0, 1'b1, 1'b0}));
          busy = 0;
        end
      end
      pw = oPO_WE; pcle = oPO_CLE; pale = oPO_ALE; pce = oPO_ChipEnable; pdq = oPO_DQ;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  edges0, lows, gap, nxt;
    bit  chain, hold;
    n_checks = 0; n_fail = 0; we_edges = 0; idle_way = '1;
    start = 1'b0; way = '1; sel = 1'b0; data = '0; num = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1 check("reset_outputs",
             64'({oReady, oLastStep, oPO_ChipEnable, oPO_CLE, oPO_ALE, oPO_WE, oPO_DQ, oPO_DQOE}),
             64'({1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0}));
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single command byte 60h.
    run_req(4'b1110, 1'b1, 40'h60_00_00_00_00, 16'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Three address bytes.
    edges0 = we_edges;
    run_req(4'b1110, 1'b0, 40'h80_12_34_00_00, 16'd2, 1'b0, 1'b0);
    @(negedge clk);
    check("addr3_we_edges", 64'(we_edges - edges0), 64'(3));
    repeat (2) @(negedge clk);

    // Erase chain with iStart held high throughout.
    edges0 = we_edges;
    run_req(4'b1011, 1'b1, 40'h60_00_00_00_00, 16'd0, 1'b0, 1'b1);
    run_req(4'b1011, 1'b0, 40'h01_02_03_00_00, 16'd2, 1'b1, 1'b1);
    run_req(4'b1011, 1'b1, 40'hD0_00_00_00_00, 16'd0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("chain_we_edges", 64'(we_edges - edges0), 64'(5));

    // Address count above the limit clamps to five bytes.
    run_req(4'b0111, 1'b0, 40'hA1_A2_A3_A4_A5, 16'h0009, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Reset in WE# low phase of the second address byte.
    way = 4'b1101; sel = 1'b0; data = 40'hC1_C2_C3_00_00; num = 16'd2; start = 1'b1;
    push_req(4'b1101, 1'b0, 40'hC1_C2_C3_00_00, 16'd2);
    lows = 0;
    for (int c = 0; c < 50 && lows < 3; c++) begin
      @(negedge clk);
      if (!oPO_WE) lows++;
    end
    check("reach_second_welow", 64'(lows), 64'(3));
    #2 rst = 1'b1;
    start = 1'b0;
    byte_q.delete();
    done_q.delete();
    #1 check("async_reset_outputs",
             64'({oReady, oLastStep, oPO_ChipEnable, oPO_CLE, oPO_ALE, oPO_WE, oPO_DQ, oPO_DQOE}),
             64'({1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0}));
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    run_req(4'b1101, 1'b1, 40'hFF_00_00_00_00, 16'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Randomised requests with random gaps, some back-to-back.
    chain = 1'b0;
    gap   = 1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] rw;
      logic         rs;
      logic [39:0]  rd;
      logic [15:0]  rn;
      nxt  = int'($urandom_range(0, 3));
      hold = (nxt == 0) && (i != 39);
      rw   = W'($urandom);
      rs   = 1'($urandom_range(0, 1));
      rd   = {8'($urandom), 32'($urandom)};
      rn   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
      if (!chain) repeat (gap) @(negedge clk);
      run_req(rw, rs, rd, rn, chain, hold);
      chain = hold;
      gap   = (nxt == 0) ? 1 : nxt;
    end

    repeat (5) @(negedge clk);
    check("bytes_drained", 64'(byte_q.size()), 64'(0));
    check("sequences_drained", 64'(done_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nfc_atom_ca_latch.md
Name: nfc_atom_ca_latch

Overview:
- Responder side of the ACG command/address-sequencer channel (ACG slot bit 3) that command blocks (erase, program, read, reset) drive.
- Accepts one command byte or 1–5 address bytes and serialises them onto the NAND pin interface: CE#, CLE, ALE, WE#, DQ, DQ output-enable. The WE# rising edge latches each byte.
- Reports oReady and a one-cycle oLastStep. These feed iACG_Ready[3] and iACG_LastStep[3] of the issuing command block.

Parameters:
- NumberOfWays, 4, number of chip-enable ways.
- SetupCycles, 1, cycles DQ/CLE/ALE are stable with WE# high before WE# falls (tCLS/tALS/tDS margin); minimum 1.
- WEPulseCycles, 2, WE# low time in cycles (tWP); minimum 1.
- WEHoldCycles, 2, WE# high time after the rising edge (tWH/tCLH/tALH/tDH); minimum 1.

Ports:
- iSystemClock  in  1  system clock (already decided).
- iReset  in  1  reset; asynchronous, active-high (already decided).
- iStart  in  1  request (command bit 3); level, held by the initiator until oLastStep.
- oReady  out  1  idle and able to accept.
- oLastStep  out  1  one-cycle pulse in the final cycle of the sequence.
- iTargetWay  in  NumberOfWays  CE# pattern, active-low.
- iCASelect  in  1  1 = command byte (CLE), 0 = address bytes (ALE).
- iCAData  in  40  bytes, MSB-first; byte0 = [39:32].
- iNumOfData  in  16  address byte count minus 1; ignored for command.
- oPO_ChipEnable  out  NumberOfWays  CE#, active-low.
- oPO_CLE  out  1  command latch enable.
- oPO_ALE  out  1  address latch enable.
- oPO_WE  out  1  WE#, active-low.
- oPO_DQ  out  8  data bus.
- oPO_DQOE  out  1  DQ driver enable.

Behaviour:
- Reset values (asynchronous): oReady=1, oLastStep=0, oPO_ChipEnable=all 1s, CLE=0, ALE=0, WE=1, DQ=8'h00, DQOE=0. FSM goes to IDLE.
- Reset mid-sequence aborts immediately with the same values; the partial byte is lost and no oLastStep is issued.
- Acceptance: in IDLE, iStart=1 with oReady=1 at a clock edge latches all of the following:
  - iTargetWay, iCASelect, iCAData into a shift register.
  - Byte count = 1 if iCASelect=1, else min(iNumOfData,4)+1. Values above 4 clamp to 5 bytes.
  - oReady drops on the same edge.
- FSM states:
  - IDLE.
  - SETUP: SetupCycles cycles. CE# asserted, CLE=iCASelect, ALE=~iCASelect, DQ=byte, DQOE=1, WE#=1.
  - WELOW: WEPulseCycles cycles, WE#=0.
  - WEHIGH: WEHoldCycles cycles, WE#=1.
  - Exit from WEHIGH: if more bytes remain, shift left 8 and return to SETUP; else go to IDLE.
- One shared down-counter times all phases. It reloads on every state change.
- Per-byte cost is S+P+H cycles; total = bytes×(S+P+H).
- oLastStep=1 exactly in the last WEHIGH cycle of the last byte.
- Next cycle (IDLE): CLE=ALE=0, DQOE=0, WE#=1, oReady=1, CE# deasserted (see Optional Feature).
- In the oLastStep cycle iStart is still high with the old data. It is not re-sampled, because the block is busy.
- A new request present in the first IDLE cycle is accepted that cycle, giving back-to-back sequences with one idle cycle between them.
- DQ changes only in SETUP, never while WE# is low.
- CLE and ALE are never both 1.
- Inputs are ignored outside IDLE.

Optional Feature:
- Macro NFC_CE_HOLD_EN.
- Defined: CE# keeps the last latched iTargetWay in IDLE after a sequence, so CE# stays low across a cmd–addr–cmd chain. CE# deasserts only on reset.
- Undefined: CE# returns to all 1s on every IDLE cycle.

Decomposition:
- Shared package nfc_acg_pkg holds:
  - State encodings (one-hot, 4 bits).
  - ACG slot index constant for the CA sequencer (3).
  - Maximum address bytes (5).
  - Default timing constants.
- One sub-module, nfc_phase_timer: loadable down-counter with a terminal-count flag, instanced once.

Test Plan:
- Command 8'h60, S/P/H=1/2/2, way pattern 4'b1110:
  - CLE=1 and DQ=8'h60 for 5 cycles; WE# low for cycles 2–3; CE#=4'b1110.
  - oLastStep in cycle 5; oReady=1 in cycle 6.
- Address, iNumOfData=2, iCAData=40'h80_12_34_00_00:
  - ALE bytes 8'h80, 8'h12, 8'h34 in order; 15 cycles; exactly 3 WE# rising edges; oLastStep once.
- Back-to-back erase chain: 60h → 3 address bytes → D0h with iStart held continuously:
  - Each request is accepted one cycle after the prior oLastStep.
  - Exactly 5 WE# edges total; no duplicate command.
- iNumOfData=16'h0009 → clamped to 5 bytes; 25 cycles.
- Reset asserted during WELOW of byte 2 → outputs return to reset values asynchronously; no oLastStep; the next request completes normally.
- NFC_CE_HOLD_EN defined vs undefined:
  - Defined: CE# stays 4'b1110 in IDLE after the sequence.
  - Undefined: CE# returns to 4'b1111.
